// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
//   PC_SEQ/PC_BR/PC_VEC : PCSrc encodings driven by the branch/redirect unit
//   VEC_RST/VEC_INT/VEC_STK : vector-select encodings (inst_mem_src / Vec_Sel)
//   NOP_INSTR : bubble instruction written into IF/ID
//   fetch_state_e : fetch sequencer states
package cpu_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;

  localparam logic [1:0] VEC_RST = 2'd1;
  localparam logic [1:0] VEC_INT = 2'd2;
  localparam logic [1:0] VEC_STK = 2'd3;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    StRstFetch,
    StVecWait,
    StRun
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, Reset_n        : clock, async active-low reset
//   flush               : load a bubble (wins over stall)
//   stall               : hold current contents
//   instr_in, pc1_in    : fetched instruction and its PC+1
//   instr, pc1, valid   : registered outputs; valid=0 marks a bubble
module if_id_reg #(
  parameter int unsigned         DATA_W    = 8,
  parameter logic [DATA_W-1:0]   NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              stall,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc1_in,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc1,
  output logic              valid
);

  logic [DATA_W-1:0] instr_q, pc1_q;
  logic              valid_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_INSTR;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      instr_q <= instr_in;
      pc1_q   <= pc1_in;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc1   = pc1_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and IF/ID, sequences reset/interrupt vector loads
// through a one-cycle-latency vector read, and raises Interrupt towards the
// branch/redirect unit.
// Ports:
//   clk, Reset_n              : clock, async active-low reset
//   Instr_In / PC_Out         : combinational instruction read at PC_Out
//   PCSrc, inst_mem_src       : redirect control (seq / branch / vector load)
//   Flush, Stall              : bubble IF/ID / hold PC and IF/ID
//   Branch_Target             : branch redirect address
//   Vec_Rd, Vec_Sel, Vec_Data : vector read strobe, source, returned word
//   Int_Req                   : external interrupt request
//   Interrupt, Int_Ack, Ret_PC: interrupt request out, take pulse, return PC
//   IF_ID_Instr/PC1/Valid     : IF/ID register contents
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter logic [DATA_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] Instr_In,
  output logic [DATA_W-1:0] PC_Out,
  input  logic [1:0]        PCSrc,
  input  logic [1:0]        inst_mem_src,
  input  logic              Flush,
  input  logic              Stall,
  input  logic [DATA_W-1:0] Branch_Target,
  output logic              Vec_Rd,
  output logic [1:0]        Vec_Sel,
  input  logic [DATA_W-1:0] Vec_Data,
  input  logic              Int_Req,
  output logic              Interrupt,
  output logic              Int_Ack,
  output logic [DATA_W-1:0] Ret_PC,
  output logic [DATA_W-1:0] IF_ID_Instr,
  output logic [DATA_W-1:0] IF_ID_PC1,
  output logic              IF_ID_Valid
);

  localparam logic [DATA_W-1:0] One = 1;

  fetch_state_e      state_q;
  logic [DATA_W-1:0] pc_q;
  logic              vec_rd_q;
  logic [1:0]        vec_sel_q;
  logic              int_pending_q;
  logic              int_ack_q;
  logic [DATA_W-1:0] ret_pc_q;

  logic [DATA_W-1:0] pc_inc;
  logic              ifid_flush;
  logic              ifid_stall;
  logic              interrupt;
  logic              take_int;

  assign pc_inc = pc_q + One;

  // Vec_Rd only stays high for the cycle that precedes VEC_WAIT's load, so
  // masking with it keeps Interrupt quiet until the vector has landed.
  assign interrupt = int_pending_q && (state_q == StRun) && !vec_rd_q;
  assign take_int  = interrupt && (PCSrc == PC_VEC);

  // IF/ID control; outside RUN the register always takes bubbles.
  always_comb begin
    ifid_flush = 1'b1;
    ifid_stall = 1'b0;
    if (state_q == StRun) begin
      case (PCSrc)
        PC_VEC, PC_BR: ifid_flush = 1'b1;
        default: begin
          if (Flush) begin
            ifid_flush = 1'b1;
          end else if (Stall) begin
            ifid_flush = 1'b0;
            ifid_stall = 1'b1;
          end else begin
            ifid_flush = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StRstFetch;
      pc_q          <= '0;
      vec_rd_q      <= 1'b0;
      vec_sel_q     <= 2'b00;
      int_pending_q <= 1'b0;
      int_ack_q     <= 1'b0;
      ret_pc_q      <= '0;
    end else begin
      vec_rd_q  <= 1'b0;
      int_ack_q <= 1'b0;

      // A request coinciding with the take edge merges into the one taken.
      if (Int_Req) int_pending_q <= 1'b1;
      if (take_int) begin
        int_pending_q <= 1'b0;
        int_ack_q     <= 1'b1;
        ret_pc_q      <= IF_ID_Valid ? (IF_ID_PC1 - One) : pc_q;
      end

      case (state_q)
        StRstFetch: begin
          vec_rd_q  <= 1'b1;
          vec_sel_q <= VEC_RST;
          state_q   <= StVecWait;
        end
        StVecWait: begin
          pc_q    <= Vec_Data;
          state_q <= StRun;
        end
        StRun: begin
          case (PCSrc)
            PC_VEC: begin
              vec_rd_q  <= 1'b1;
              vec_sel_q <= (inst_mem_src == 2'b00) ? VEC_RST : inst_mem_src;
              state_q   <= StVecWait;
            end
            PC_BR: pc_q <= Branch_Target;
            default: begin
              if (Flush || !Stall) pc_q <= pc_inc;
            end
          endcase
        end
        default: state_q <= StRstFetch;
      endcase
    end
  end

  if_id_reg #(
    .DATA_W   (DATA_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .Reset_n (Reset_n),
    .flush   (ifid_flush),
    .stall   (ifid_stall),
    .instr_in(Instr_In),
    .pc1_in  (pc_inc),
    .instr   (IF_ID_Instr),
    .pc1     (IF_ID_PC1),
    .valid   (IF_ID_Valid)
  );

  assign PC_Out    = pc_q;
  assign Vec_Rd    = vec_rd_q;
  assign Vec_Sel   = vec_sel_q;
  assign Interrupt = interrupt;
  assign Int_Ack   = int_ack_q;
  assign Ret_PC    = ret_pc_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage directly downstream of the branch/redirect unit.
- Owns the 8-bit PC and the IF/ID pipeline register, and applies PCSrc, inst_mem_src and Flush from the branch/redirect unit.
- Sequences the reset-vector and interrupt-vector loads, using a one-cycle-latency vector read.
- Generates the Interrupt request consumed by the branch/redirect unit.

Parameters:
- DATA_W, 8, width of PC, instruction and vector data.
- NOP_INSTR, 8'h00, bubble written into IF/ID on flush.

Ports:
- clk  in  1  single clock; everything is updated on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Instr_In  in  8  instruction read from instruction memory at PC_Out (combinational read).
- PC_Out  out  8  current PC.
- PCSrc  in  2  from branch/redirect unit: 00 sequential, 01 branch target, 10 vector load.
- inst_mem_src  in  2  from branch/redirect unit: 1 reset vector M[0], 2 interrupt vector M[1], 3 stack top (RET/RTI).
- Flush  in  1  from branch/redirect unit: IF/ID gets a bubble.
- Stall  in  1  hazard stall: hold PC and IF/ID.
- Branch_Target  in  8  redirect address (the Rb value of the instruction in EX).
- Vec_Rd  out  1  vector read strobe.
- Vec_Sel  out  2  vector source for the read, same encoding as inst_mem_src.
- Vec_Data  in  8  vector/stack word; valid one cycle after Vec_Rd.
- Int_Req  in  1  external interrupt request, level or pulse.
- Interrupt  out  1  to branch/redirect unit: take the interrupt now.
- Int_Ack  out  1  one-cycle pulse when the interrupt is taken.
- Ret_PC  out  8  return address for the interrupt push.
- IF_ID_Instr  out  8  registered instruction.
- IF_ID_PC1  out  8  registered PC+1 of that instruction.
- IF_ID_Valid  out  1  0 when IF/ID holds a bubble.

Behaviour:
- Reset_n low (async) sets:
  - PC=0, state=RST_FETCH.
  - IF_ID_Instr=NOP_INSTR, IF_ID_PC1=0, IF_ID_Valid=0.
  - Int_Pending=0, Interrupt=0, Int_Ack=0, Ret_PC=0.
  - Vec_Rd=0, Vec_Sel=00.
- State machine states: RST_FETCH, VEC_WAIT, RUN.
- RST_FETCH (first edge after release):
  - Vec_Rd=1, Vec_Sel=01.
  - Next state VEC_WAIT; PC holds; IF/ID loads a bubble.
- VEC_WAIT:
  - PC <= Vec_Data; IF/ID loads a bubble; Vec_Rd=0; next state RUN.
  - PCSrc, Flush and Stall are ignored in this state.
- RUN, priority order:
  1. PCSrc=10: latch inst_mem_src into Vec_Sel, Vec_Rd=1 for one cycle, PC holds, IF/ID bubble, next state VEC_WAIT.
  2. PCSrc=01: PC <= Branch_Target; IF/ID bubble.
  3. Flush=1 with PCSrc=00: PC <= PC+1; IF/ID bubble.
  4. Stall=1: PC and IF/ID hold.
  5. Otherwise: PC <= PC+1; IF/ID <= {Instr_In, PC+1, valid=1}.
- A redirect (PCSrc≠00) wins over Stall.
- PC+1 is modulo 256 (8'hFF -> 8'h00). The Vec_Sel output is registered.
- Interrupt handling:
  - Int_Pending is set on any clk edge with Int_Req=1. Repeated requests while pending merge into one.
  - Interrupt = Int_Pending && state==RUN && !Vec_Rd. It is combinational from registered state.
  - On an edge where Interrupt=1 and PCSrc=10 (the branch/redirect unit responds with inst_mem_src=2):
    - Int_Pending <= 0 and Int_Ack <= 1 for one cycle.
    - Ret_PC <= IF_ID_Valid ? IF_ID_PC1-1 : PC.
    - The normal PCSrc=10 path runs.
- Requests arriving in RST_FETCH or VEC_WAIT stay pending and are taken on the first RUN cycle.
- Reset mid-vector-load aborts the load and restarts at RST_FETCH.
- inst_mem_src=0 with PCSrc=10 is treated as 1.

Decomposition:
- Shared package (cpu_pkg):
  - PCSrc encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_VEC=2'b10.
  - Vector-select encodings VEC_RST=1, VEC_INT=2, VEC_STK=3.
  - NOP_INSTR.
  - State enum.
- Sub-module if_id_reg: IF/ID register with flush-to-bubble and stall-hold. The PC, state machine and interrupt logic stay in the top module.

Test Plan:
- Reset sequence: release Reset_n with M[0]=8'h20 → Vec_Rd=1/Vec_Sel=01 on cycle 1, PC=8'h20 after cycle 2, IF_ID_Valid=0 for both cycles, then sequential fetch of 8'h20, 8'h21.
- Wrap: PC=8'hFF, PCSrc=00 → PC=8'h00, IF_ID_PC1=8'h00.
- Branch during stall: PC=8'h10, Stall=1, PCSrc=01, Branch_Target=8'h40 → PC=8'h40, IF/ID bubble (Instr=8'h00, Valid=0).
- Interrupt:
  - Setup: Int_Req pulse with IF_ID_PC1=8'h31, Valid=1, then PCSrc=10/inst_mem_src=2, M[1]=8'h80.
  - Required: Interrupt=1 the cycle after the pulse, Int_Ack pulse, Ret_PC=8'h30, PC=8'h80 two edges later.
- Interrupt during vector load: Int_Req during VEC_WAIT of a RET (Vec_Data=8'h55) → PC=8'h55, then Interrupt=1 on the first RUN cycle.
- Async reset: assert Reset_n mid-VEC_WAIT, without a clock edge → PC=0 and IF/ID bubble immediately; the restart performs the reset-vector fetch again.
